des_expand_mix: RTL and testbench

DES_EXPAND_MIX -- requirements
Module: des_expand_mix

---
 rtl/des_expand_mix_if.sv | 29 ++
 rtl/des_expand_mix.sv | 93 +++++++++
 tb/tb_des_expand_mix.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/des_expand_mix_if.sv
// Bundle of the subkey-write port and the two valid/ready word ports
// of the DES expansion/key-mix stage.
interface des_expand_mix_if;
    logic        key_we;
    logic [3:0]  key_addr;
    logic [47:0] key_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_r;
    logic [3:0]  in_round;
    logic        out_valid;
    logic        out_ready;
    logic [47:0] out_x;
    logic [3:0]  out_round;

    modport master (
        output key_we, key_addr, key_data,
        output in_valid, in_r, in_round,
        output out_ready,
        input  in_ready, out_valid, out_x, out_round
    );

    modport slave (
        input  key_we, key_addr, key_data,
        input  in_valid, in_r, in_round,
        input  out_ready,
        output in_ready, out_valid, out_x, out_round
    );
endinterface

// File: rtl/des_expand_mix.sv
// DES round front end: expands the 32-bit right half to 48 bits, mixes in
// the round subkey from a 16-entry store, and hands eight 6-bit S-box
// inputs downstream through a two-stage valid/ready pipeline.
module des_expand_mix (
    input  logic            clk,
    input  logic            reset,
    des_expand_mix_if.slave bus
);

    logic [47:0] key_store [16];

    logic        vld_p0;
    logic [47:0] e_p0;
    logic [47:0] key_p0;
    logic [3:0]  round_p0;

    logic        vld_p1;
    logic [47:0] x_p1;
    logic [3:0]  round_p1;

    logic        adv_p0;
    logic        adv_p1;

    // DES E expansion. Output group j (S-box j+1) takes R bits 4j..4j+5
    // in DES numbering, wrapping 0 -> 32 and 33 -> 1. DES bit n of R is
    // r[32-n]; output position m is e[48-m].
    function automatic logic [47:0] des_expand(input logic [31:0] r);
        logic [47:0] e;
        int t;
        e = '0;
        for (int j = 0; j < 8; j++) begin
            for (int k = 0; k < 6; k++) begin
                t = (4 * j + k + 31) % 32;
                e[47 - (6 * j + k)] = r[31 - t];
            end
        end
        return e;
    endfunction

    // A stage may load when it is empty or its contents move on this cycle.
    always_comb begin
        adv_p1 = ~vld_p1 | bus.out_ready;
        adv_p0 = ~vld_p0 | adv_p1;
    end

    assign bus.in_ready  = adv_p0;
    assign bus.out_valid = vld_p1;
    assign bus.out_x     = x_p1;
    assign bus.out_round = round_p1;

    // Subkey store; the stage-A read below sees the pre-edge contents, so a
    // same-cycle write to the entry being read only affects later words.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) key_store[i] <= '0;
        end else if (bus.key_we) begin
            key_store[bus.key_addr] <= bus.key_data;
        end
    end

    // ---- stage A (p0): expansion and subkey fetch on input acceptance ----
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p0   <= 1'b0;
            e_p0     <= '0;
            key_p0   <= '0;
            round_p0 <= '0;
        end else if (adv_p0) begin
            vld_p0 <= bus.in_valid;
            if (bus.in_valid) begin
                e_p0     <= des_expand(bus.in_r);
                key_p0   <= key_store[bus.in_round];
                round_p0 <= bus.in_round;
            end
        end
    end

    // ---- stage B (p1): key mix into the output register ----
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1   <= 1'b0;
            x_p1     <= '0;
            round_p1 <= '0;
        end else if (adv_p1) begin
            vld_p1 <= vld_p0;
            if (vld_p0) begin
                x_p1     <= e_p0 ^ key_p0;
                round_p1 <= round_p0;
            end
        end
    end

endmodule

// File: tb/tb_des_expand_mix.sv
// Scoreboard bench for des_expand_mix: a reference model computes each
// accepted word's result, queues it, and compares it when it leaves.
module tb_des_expand_mix;

    logic clk;
    logic reset;

    des_expand_mix_if bus ();

    des_expand_mix dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // DES E table: R bit number feeding each output position 1..48.
    localparam int ETAB [48] = '{
        32, 1, 2, 3, 4, 5,     4, 5, 6, 7, 8, 9,
        8, 9, 10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1
    };

    int n_checks = 0;
    int n_fail   = 0;

    logic [47:0] mkey [16];
    logic [51:0] sb [$];
    logic [47:0] pop_log [$];

    logic        s_in_ready, s_out_valid, s_acc, s_pop;
    logic [47:0] s_x;
    logic [3:0]  s_round;

    function automatic logic [47:0] ref_expand(input logic [31:0] r);
        logic [47:0] e;
        for (int m = 1; m <= 48; m++) e[48 - m] = r[32 - ETAB[m - 1]];
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: entered at a falling edge with inputs set; samples just
    // before the rising edge, updates the model, returns at the next fall.
    task automatic step();
        logic [51:0] e;
        #4;
        s_in_ready  = bus.in_ready;
        s_out_valid = bus.out_valid;
        s_x         = bus.out_x;
        s_round     = bus.out_round;
        s_acc       = bus.in_valid && s_in_ready;
        s_pop       = s_out_valid && bus.out_ready;
        if (reset) begin
            sb.delete();
            for (int i = 0; i < 16; i++) mkey[i] = '0;
            s_acc = 1'b0;
            s_pop = 1'b0;
        end else begin
            if (s_pop) begin
                pop_log.push_back(s_x);
                if (sb.size() == 0) begin
                    chk("sb_underflow", 64'(sb.size()), 64'd1);
                end else begin
                    e = sb.pop_front();
                    chk("out_x", 64'(s_x), 64'(e[47:0]));
                    chk("out_round", 64'(s_round), 64'(e[51:48]));
                end
            end
            if (s_acc)
                sb.push_back({bus.in_round, ref_expand(bus.in_r) ^ mkey[bus.in_round]});
            if (bus.key_we) mkey[bus.key_addr] = bus.key_data;
        end
        @(negedge clk);
    endtask

    // Send one word into an empty pipe and wait for it to come out.
    task automatic send_wait(input logic [31:0] r, input logic [3:0] rnd,
                             output logic [47:0] x, output int lat);
        logic got;
        got = 1'b0;
        x   = '0;
        lat = -1;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_r      = r;
        bus.in_round  = rnd;
        for (int i = 0; i < 20; i++) begin
            step();
            if (s_acc) break;
        end
        bus.in_valid = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (s_pop) begin
                x   = s_x;
                lat = i;
                got = 1'b1;
                break;
            end
        end
        chk("send_done", 64'(got), 64'd1);
    endtask

    initial begin
        logic [47:0] x, x1, x2, hold;
        logic [47:0] ka, kb;
        int lat, acc, pops, first_p, last_p, guard;

        reset = 1'b1;
        bus.key_we = 1'b0; bus.key_addr = '0; bus.key_data = '0;
        bus.in_valid = 1'b0; bus.in_r = '0; bus.in_round = '0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 16; i++) mkey[i] = '0;
        @(negedge clk);
        step();
        step();
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_x", 64'(bus.out_x), 64'd0);
        chk("rst_out_round", 64'(bus.out_round), 64'd0);
        reset = 1'b0;
        step();
        chk("rst_in_ready", 64'(s_in_ready), 64'd1);

        // Classic DES round-1 example.
        bus.key_we = 1'b1; bus.key_addr = 4'd0; bus.key_data = 48'h1B02EFFC7072;
        step();
        bus.key_we = 1'b0;
        send_wait(32'hF0AAF0AA, 4'd0, x, lat);
        chk("req30_x", 64'(x), 64'h6117BA866527);
        chk("req30_round", 64'(s_round), 64'd0);
        chk("req30_latency", 64'(lat), 64'd2);

        // Expansion wrap-around bits with a zero subkey.
        send_wait(32'h00000001, 4'd1, x, lat);
        chk("req31_lsb", 64'(x), 64'h800000000002);
        send_wait(32'h80000000, 4'd1, x, lat);
        chk("req31_msb", 64'(x), 64'h400000000001);

        // Back-to-back stream of 8 words.
        pop_log.delete();
        acc = 0; pops = 0; first_p = -1; last_p = -1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus.in_valid = (acc < 8);
            bus.in_r     = 32'h13579BDF * (acc + 1);
            bus.in_round = 4'(acc);
            step();
            if (s_acc) acc++;
            if (s_pop) begin
                if (first_p < 0) first_p = i;
                last_p = i;
                pops++;
            end
        end
        bus.in_valid = 1'b0;
        chk("stream_pops", 64'(pops), 64'd8);
        chk("stream_consecutive", 64'(last_p - first_p), 64'd7);

        // Stall: only two more words fit, output holds.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        acc = 0;
        hold = '0;
        for (int i = 0; i < 5; i++) begin
            bus.in_r     = 32'hCAFE0000 + 32'(i);
            bus.in_round = 4'(i + 3);
            step();
            if (s_acc) begin
                acc++;
                bus.in_r = bus.in_r + 32'h100;
            end
            if (i == 2) hold = s_x;
        end
        chk("stall_accepts", 64'(acc), 64'd2);
        chk("stall_in_ready", 64'(s_in_ready), 64'd0);
        chk("stall_out_valid", 64'(s_out_valid), 64'd1);
        chk("stall_hold_x", 64'(s_x), 64'(hold));
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) step();
        chk("stall_drain", 64'(sb.size()), 64'd0);

        // Same-cycle write and read of entry 5.
        ka = 48'hA5A5_0F0F_3C3C;
        kb = 48'h1234_5678_9ABC;
        bus.key_we = 1'b1; bus.key_addr = 4'd5; bus.key_data = ka;
        step();
        pop_log.delete();
        bus.key_data = kb;
        bus.in_valid = 1'b1; bus.in_r = 32'h0F0F1234; bus.in_round = 4'd5;
        step();
        chk("req33_first_acc", 64'(s_acc), 64'd1);
        bus.key_we = 1'b0;
        step();
        chk("req33_second_acc", 64'(s_acc), 64'd1);
        bus.in_valid = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("req33_pops", 64'(pop_log.size()), 64'd2);
        x1 = (pop_log.size() > 0) ? pop_log[0] : '0;
        x2 = (pop_log.size() > 1) ? pop_log[1] : '0;
        chk("req33_key_delta", 64'(x1 ^ x2), 64'(ka ^ kb));

        // Reset with both stages full.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1; bus.in_r = 32'h55AA55AA; bus.in_round = 4'd5;
        acc = 0;
        for (int i = 0; i < 10 && acc < 2; i++) begin
            step();
            if (s_acc) acc++;
        end
        bus.in_valid = 1'b0;
        chk("req34_filled", 64'(acc), 64'd2);
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        chk("req34_out_valid", 64'(s_out_valid), 64'd0);
        chk("req34_out_x", 64'(s_x), 64'd0);
        chk("req34_in_ready", 64'(s_in_ready), 64'd1);
        bus.out_ready = 1'b1;
        pops = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (s_pop) pops++;
        end
        chk("req34_no_ghost", 64'(pops), 64'd0);
        send_wait(32'h00000001, 4'd5, x, lat);
        chk("req34_key_cleared", 64'(x), 64'h800000000002);

        // Random traffic against the model.
        acc = 0;
        guard = 0;
        while (acc < 10000 && guard < 60000) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.in_r      = $urandom;
            bus.in_round  = 4'($urandom_range(0, 15));
            bus.key_we    = ($urandom_range(0, 15) == 0);
            bus.key_addr  = 4'($urandom_range(0, 15));
            bus.key_data  = {16'($urandom), 32'($urandom)};
            step();
            if (s_acc) acc++;
            guard++;
        end
        bus.in_valid = 1'b0; bus.key_we = 1'b0; bus.out_ready = 1'b1;
        for (int i = 0; i < 20 && sb.size() != 0; i++) step();
        chk("rand_words", 64'(acc), 64'd10000);
        chk("rand_drain", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
